// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-flow controller: IDLE/RUN/PAUSE/DEAD sequencing, per-frame bird motion, BCD score/best.
// Latency: every output is registered; frame, score and button effects appear one cycle after the causing input.
// Backpressure: none; frame_tick and pipe_passed are single-cycle pulses and are consumed in the cycle they arrive.
module flappy_game_ctrl #(
    parameter int GRAVITY     = 1,
    parameter int JUMP_V      = 8,
    parameter int MAX_FALL    = 10,
    parameter int START_Y     = 240,
    parameter int GROUND_Y    = 440,
    parameter int DEAD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        enable_btn,
    input  logic        collision,
    input  logic        pipe_passed,
    output logic [1:0]  state,
    output logic [9:0]  bird_y,
    output logic        pipe_advance,
    output logic [15:0] score,
    output logic [15:0] best
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    localparam int DW = $clog2(DEAD_FRAMES + 1);

    localparam logic signed [7:0]  VEL_JUMP  = -signed'(8'(JUMP_V));
    localparam logic signed [7:0]  VEL_GRAV  = signed'(8'(GRAVITY));
    localparam logic signed [7:0]  VEL_MAX   = signed'(8'(MAX_FALL));
    localparam logic signed [10:0] GROUND_11 = signed'(11'(GROUND_Y));
    localparam logic [9:0]         GROUND_10 = 10'(GROUND_Y);
    localparam logic [9:0]         START_10  = 10'(START_Y);
    localparam logic [DW-1:0]      DEAD_MAX  = DW'(DEAD_FRAMES);

    state_t             state_q;
    logic [9:0]         bird_y_q;
    logic signed [7:0]  vel_q;
    logic               pipe_advance_q;
    logic [15:0]        score_q;
    logic [15:0]        best_q;
    logic [DW-1:0]      dead_cnt_q;
    logic               jump_pend_q;
    logic               jump_btn_q;
    logic               enable_btn_q;

    logic               jump_rise;
    logic               enable_rise;
    logic signed [7:0]  vel_grav;
    logic signed [7:0]  vel_d;
    logic signed [10:0] y_sum;
    logic               hit_ceiling;
    logic               hit_ground;
    logic [9:0]         bird_y_d;
    logic [15:0]        score_d;
    logic               run_die;

    // Four-digit BCD increment with per-digit carry; 9999 is sticky.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Button edges, next-frame motion, clamping and score increment.
    always_comb begin
        jump_rise   = jump_btn & ~jump_btn_q;
        enable_rise = enable_btn & ~enable_btn_q;
        vel_grav    = vel_q + VEL_GRAV;
        vel_d       = vel_grav;
        if (jump_pend_q || jump_rise) begin
            vel_d = VEL_JUMP;
        end else if (vel_grav > VEL_MAX) begin
            vel_d = VEL_MAX;
        end
        // Bird row is zero-extended, velocity sign-extended, so the sum can go negative at the ceiling.
        y_sum       = signed'({1'b0, bird_y_q}) + signed'({{3{vel_d[7]}}, vel_d});
        hit_ceiling = y_sum[10];
        hit_ground  = !hit_ceiling && (y_sum >= GROUND_11);
        bird_y_d    = y_sum[9:0];
        if (hit_ceiling) begin
            bird_y_d = 10'd0;
        end else if (hit_ground) begin
            bird_y_d = GROUND_10;
        end
        score_d = pipe_passed ? bcd_inc(score_q) : score_q;
        run_die = frame_tick && (hit_ground || collision);
    end

    // Game FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q        <= S_IDLE;
            bird_y_q       <= START_10;
            vel_q          <= '0;
            pipe_advance_q <= 1'b0;
            score_q        <= '0;
            best_q         <= '0;
            dead_cnt_q     <= '0;
            jump_pend_q    <= 1'b0;
            jump_btn_q     <= 1'b1;
            enable_btn_q   <= 1'b1;
        end else begin
            jump_btn_q     <= jump_btn;
            enable_btn_q   <= enable_btn;
            pipe_advance_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    bird_y_q    <= START_10;
                    vel_q       <= '0;
                    jump_pend_q <= 1'b0;
                    if (jump_rise) begin
                        state_q <= S_RUN;
                        score_q <= '0;
                        vel_q   <= VEL_JUMP;
                    end
                end
                S_RUN: begin
                    score_q <= score_d;
                    if (frame_tick) begin
                        vel_q          <= vel_d;
                        bird_y_q       <= bird_y_d;
                        pipe_advance_q <= 1'b1;
                        jump_pend_q    <= 1'b0;
                    end else if (jump_rise) begin
                        jump_pend_q <= 1'b1;
                    end
                    // Death wins over a simultaneous pause request.
                    if (run_die) begin
                        state_q    <= S_DEAD;
                        dead_cnt_q <= '0;
                        best_q     <= (score_d > best_q) ? score_d : best_q;
                    end else if (enable_rise) begin
                        state_q     <= S_PAUSE;
                        jump_pend_q <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (enable_rise) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    if (frame_tick && (dead_cnt_q != DEAD_MAX)) begin
                        dead_cnt_q <= dead_cnt_q + 1'b1;
                    end
                    // Early jump edges are simply dropped.
                    if (jump_rise && (dead_cnt_q == DEAD_MAX)) begin
                        state_q  <= S_IDLE;
                        bird_y_q <= START_10;
                        vel_q    <= '0;
                    end
                end
            endcase
        end
    end

    assign state        = state_q;
    assign bird_y       = bird_y_q;
    assign pipe_advance = pipe_advance_q;
    assign score        = score_q;
    assign best         = best_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: behavioural game model feeds an expected queue, observed outputs feed a second queue.
// Each scenario task drains both queues and compares them in order.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_flappy_game_ctrl;

    localparam int T_START = 240;
    localparam int T_GROUND = 440;
    localparam int T_JUMP = 8;
    localparam int T_MAXF = 10;
    localparam int T_DEADF = 60;

    logic        clk = 1'b0;
    logic        clr, frame_tick, jump_btn, enable_btn, collision, pipe_passed;
    logic [1:0]  state;
    logic [9:0]  bird_y;
    logic        pipe_advance;
    logic [15:0] score, best;

    int checks = 0;
    int failures = 0;

    // model state
    int m_state, m_y, m_vel, m_score, m_best, m_pend, m_dcnt;

    logic [44:0] expq[$];
    logic [44:0] obsq[$];

    flappy_game_ctrl dut (
        .clk(clk), .clr(clr), .frame_tick(frame_tick), .jump_btn(jump_btn),
        .enable_btn(enable_btn), .collision(collision), .pipe_passed(pipe_passed),
        .state(state), .bird_y(bird_y), .pipe_advance(pipe_advance),
        .score(score), .best(best)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int pa);
        expq.push_back({2'(m_state), 10'(m_y), 1'(pa), to_bcd(m_score), to_bcd(m_best)});
        obsq.push_back({state, bird_y, pipe_advance, score, best});
    endtask

    task automatic m_reset();
        m_state = 0; m_y = T_START; m_vel = 0; m_score = 0; m_best = 0; m_pend = 0; m_dcnt = 0;
    endtask

    task automatic m_die();
        m_state = 3;
        if (m_score > m_best) m_best = m_score;
        m_dcnt = 0;
    endtask

    task automatic m_frame(input int coll, input int pp, output int pa);
        int v, y, d;
        pa = 0;
        if (m_state == 1) begin
            v = (m_pend != 0) ? -T_JUMP : ((m_vel + 1 > T_MAXF) ? T_MAXF : m_vel + 1);
            y = m_y + v;
            d = coll;
            if (y < 0) y = 0;
            else if (y >= T_GROUND) begin y = T_GROUND; d = 1; end
            m_vel = v; m_y = y; m_pend = 0; pa = 1;
            if (pp != 0 && m_score < 9999) m_score++;
            if (d != 0) m_die();
        end else if (m_state == 3) begin
            if (m_dcnt < T_DEADF) m_dcnt++;
        end
    endtask

    task automatic drive_frame(input int coll, input int pp);
        int pa;
        frame_tick = 1'b1; collision = 1'(coll); pipe_passed = 1'(pp);
        m_frame(coll, pp, pa);
        cyc();
        record(pa);
        frame_tick = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
        cyc();
        record(0);
    endtask

    task automatic drive_jump();
        jump_btn = 1'b1;
        if (m_state == 0) begin
            m_state = 1; m_score = 0; m_vel = -T_JUMP; m_pend = 0;
        end else if (m_state == 1) begin
            m_pend = 1;
        end else if (m_state == 3 && m_dcnt == T_DEADF) begin
            m_state = 0; m_y = T_START; m_vel = 0;
        end
        cyc();
        record(0);
        jump_btn = 1'b0;
        cyc();
    endtask

    task automatic drive_enable();
        enable_btn = 1'b1;
        if (m_state == 1) begin
            m_state = 2; m_pend = 0;
        end else if (m_state == 2) begin
            m_state = 1;
        end
        cyc();
        record(0);
        enable_btn = 1'b0;
        cyc();
    endtask

    task automatic drive_pipes(input int n);
        pipe_passed = 1'b1;
        repeat (n) cyc();
        pipe_passed = 1'b0;
        if (m_state == 1) m_score = (m_score + n > 9999) ? 9999 : m_score + n;
        record(0);
        cyc();
    endtask

    task automatic test_reset();
        clr = 1'b1; jump_btn = 1'b1; enable_btn = 1'b0;
        frame_tick = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
        cyc(); cyc();
        m_reset();
        record(0);
        clr = 1'b0;
        repeat (10) drive_frame(0, 0);
        jump_btn = 1'b0;
        cyc();
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset: got %h want %h", o, e); end
        end
    endtask

    task automatic test_start_motion();
        drive_jump();
        repeat (3) drive_frame(0, 0);
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL start_motion: got %h want %h", o, e); end
        end
    endtask

    task automatic test_score_death();
        repeat (12) begin
            pipe_passed = 1'b1;
            if (m_state == 1) m_score++;
            cyc();
            record(0);
            pipe_passed = 1'b0;
            cyc();
        end
        drive_frame(1, 0);
        repeat (5) drive_frame(0, 0);
        drive_jump();
        repeat (55) drive_frame(0, 0);
        drive_jump();
        drive_jump();
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL score_death: got %h want %h", o, e); end
        end
    endtask

    task automatic test_free_fall_ceiling();
        int guard;
        guard = 0;
        while (m_state == 1 && guard < 100) begin
            drive_frame(0, 0);
            guard++;
        end
        checks++;
        if (state !== 2'd3 || bird_y !== 10'd440)
            begin failures++; $display("FAIL ground_clamp: got state=%0d y=%0d want state=3 y=440", state, bird_y); end
        repeat (T_DEADF) drive_frame(0, 0);
        drive_jump();
        drive_jump();
        repeat (40) begin
            drive_jump();
            drive_frame(0, 0);
        end
        checks++;
        if (state !== 2'd1 || bird_y !== 10'd0)
            begin failures++; $display("FAIL ceiling_clamp: got state=%0d y=%0d want state=1 y=0", state, bird_y); end
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL free_fall: got %h want %h", o, e); end
        end
    endtask

    task automatic test_pause();
        drive_enable();
        repeat (5) drive_frame(1, 1);
        drive_jump();
        drive_enable();
        drive_frame(0, 0);
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL pause: got %h want %h", o, e); end
        end
    endtask

    task automatic test_bcd();
        drive_pipes(99);
        drive_pipes(1);
        drive_pipes(9899);
        drive_pipes(5);
        drive_frame(1, 1);
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL bcd: got %h want %h", o, e); end
        end
    endtask

    task automatic test_clr_mid_run();
        repeat (T_DEADF) drive_frame(0, 0);
        drive_jump();
        drive_jump();
        drive_pipes(1);
        jump_btn = 1'b1;
        cyc();
        clr = 1'b1;
        cyc();
        m_reset();
        record(0);
        clr = 1'b0;
        cyc();
        jump_btn = 1'b0;
        cyc();
        drive_frame(0, 0);
        drive_jump();
        drive_frame(0, 0);
        while (expq.size() > 0) begin
            logic [44:0] e, o;
            e = expq.pop_front(); o = obsq.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL clr_mid_run: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_start_motion();
        test_score_death();
        test_free_fall_ceiling();
        test_pause();
        test_bcd();
        test_clr_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
